multibyte_adder_seq: RTL and testbench

- Byte-serial controller that sequences one 8-bit add slice to perform NBYTES-wide add or subtract.
- Accepts an operand pair over a valid/ready handshake and processes one byte per clock, LSB first, through a registered carry.
- Returns the sum, carry-out and signed overflow over a second valid/ready handshake.
- Sits between the arithmetic datapath's 8-bit adder slice and any client that needs wide arithmetic without a wide adder.

---
 rtl/multibyte_adder_seq_pkg.sv | 12 +
 rtl/adder_byte_slice.sv | 12 +
 rtl/multibyte_adder_seq.sv | 105 ++++++++++
 tb/tb_multibyte_adder_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multibyte_adder_seq_pkg.sv
// Shared constants and state encoding for the byte-serial wide adder.
package multibyte_adder_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_byte_slice.sv
// Combinational 8-bit add slice with carry-in and carry-out.
module adder_byte_slice (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {8'b0, ci};

endmodule

// File: rtl/multibyte_adder_seq.sv
// Byte-serial NBYTES-wide add/subtract built around one shared 8-bit slice,
// LSB first through a registered carry, with valid/ready on both sides.
module multibyte_adder_seq
  import multibyte_adder_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [8*NBYTES-1:0]    a,
  input  logic [8*NBYTES-1:0]    b,
  input  logic                   cin,
  input  logic                   sub,
  output logic                   done_valid,
  input  logic                   done_ready,
  output logic [8*NBYTES-1:0]    sum,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [W-1:0]       a_sh, b_sh, sum_sh;
  logic               cout_r, ovf_r;
  logic [BYTE_W-1:0]  slice_s;
  logic               slice_co;
  logic               accept, last_byte;

  assign accept    = start_valid && (state == IDLE);
  assign last_byte = (state == RUN) && (idx == LAST_IDX);

  adder_byte_slice u_slice (
    .x  (a_sh[BYTE_W-1:0]),
    .y  (b_sh[BYTE_W-1:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_byte) state_next = DONE;
      DONE:    if (done_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the operand shifters are reset along with the visible result so a
  // mid-operation reset leaves no stale data anywhere in the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= sub | cin;
      idx   <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> BYTE_W;
      b_sh   <= b_sh >> BYTE_W;
      sum_sh <= {slice_s, sum_sh[W-1:BYTE_W]};
      carry  <= slice_co;
      idx    <= idx + 1'b1;
      if (last_byte) begin
        // Top byte is in the slice now: its bit 7 carries the sign.
        cout_r <= slice_co;
        ovf_r  <= (a_sh[BYTE_W-1] == b_sh[BYTE_W-1]) &&
                  (slice_s[BYTE_W-1] != a_sh[BYTE_W-1]);
      end
    end
  end

  assign start_ready = (state == IDLE);
  assign done_valid  = (state == DONE);
  assign busy        = (state != IDLE);
  assign sum         = sum_sh;
  assign cout        = cout_r;
  assign ovf         = ovf_r;

endmodule

// File: tb/tb_multibyte_adder_seq.sv
// Directed bench for multibyte_adder_seq: a wide-arithmetic reference model
// checked every cycle, plus hand-computed literal results.
module tb_multibyte_adder_seq;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  logic         clk;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         done_valid;
  logic         done_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  multibyte_adder_seq #(.NBYTES(NBYTES)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sub         (sub),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference result from whole-word arithmetic and signed range.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    res_t         r;
    logic [W:0]   t;
    longint       sx, sy, sr;
    longint       smax, smin;
    smax = (64'sd1 <<< (W - 1)) - 1;
    smin = -(64'sd1 <<< (W - 1));
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (sb) begin
      r.s = x - y;
      r.c = (x >= y);
      sr  = sx - sy;
    end else begin
      t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      r.s = t[W-1:0];
      r.c = t[W];
      sr  = sx + sy + longint'(ci);
    end
    r.o = (sr > smax) || (sr < smin);
    return r;
  endfunction

  // Transaction-level model: at most one operation in flight.
  res_t exp_q[$];
  res_t last_res = '0;
  bit   in_flight = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   acc_log[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight = 0;
      exp_q.delete();
      last_res = '0;
    end else begin
      if (in_flight && (cyc - acc_cyc >= NBYTES)) begin
        if (done_ready) begin
          last_res  = exp_q.pop_front();
          in_flight = 0;
        end
      end else if (!in_flight && start_valid) begin
        exp_q.push_back(model(a, b, cin, sub));
        in_flight = 1;
        acc_cyc   = cyc + 1;
        acc_log.push_back(cyc + 1);
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rst_done_valid", done_valid, 0);
      check("rst_start_ready", start_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
    end else begin
      automatic bit exp_dv = in_flight && (cyc - acc_cyc >= NBYTES);
      check("done_valid", done_valid, exp_dv);
      check("start_ready", start_ready, !in_flight);
      check("busy", busy, in_flight);
      if (exp_dv) begin
        check("result_sum", sum, exp_q[0].s);
        check("result_cout", cout, exp_q[0].c);
        check("result_ovf", ovf, exp_q[0].o);
      end else if (!in_flight) begin
        check("idle_sum", sum, last_res.s);
        check("idle_cout", cout, last_res.c);
        check("idle_ovf", ovf, last_res.o);
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    while (!done_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", done_valid, 1);
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                       input logic tcin, input logic tsub,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    int n = 0;
    @(negedge clk);
    a = ta; b = tbv; cin = tcin; sub = tsub;
    start_valid = 1'b1; done_ready = 1'b1;
    while (!start_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", start_ready, 1);
    @(negedge clk);
    start_valid = 1'b0;
    wait_done();
    check("lit_sum", sum, es);
    check("lit_cout", cout, ec);
    check("lit_ovf", ovf, eo);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] hs;
    logic         hc, ho;
    rst = 1'b1;
    start_valid = 1'b0; done_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    do_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Result held under back-pressure while a new request waits.
    @(negedge clk);
    a = 32'h7FFF_FFFF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0;
    start_valid = 1'b1; done_ready = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    wait_done();
    hs = sum; hc = cout; ho = ovf;
    check("hold_first_sum", hs, 32'h8000_0000);
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b1; sub = 1'b0;
    start_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("hold_sum", sum, hs);
      check("hold_cout", cout, hc);
      check("hold_ovf", ovf, ho);
      check("hold_start_ready", start_ready, 0);
      check("hold_done_valid", done_valid, 1);
    end
    done_ready = 1'b1;
    @(negedge clk);
    check("release_start_ready", start_ready, 1);
    check("release_busy", busy, 0);
    @(negedge clk);
    check("pending_accepted", busy, 1);
    start_valid = 1'b0;
    wait_done();
    check("cin_sum", sum, 32'h2345_678A);
    check("cin_cout", cout, 0);
    @(negedge clk);

    // Back-to-back requests with done_ready tied high.
    acc_log.delete();
    a = 32'h0000_FFFF; b = 32'h0001_0001; cin = 1'b0; sub = 1'b1;
    start_valid = 1'b1;
    repeat (3 * (NBYTES + 2) + 1) @(negedge clk);
    start_valid = 1'b0;
    check("b2b_accepts", acc_log.size(), 4);
    for (int i = 1; i < acc_log.size(); i++)
      check("b2b_spacing", acc_log[i] - acc_log[i-1], NBYTES + 2);
    wait_done();
    check("b2b_sum", sum, 32'hFFFF_FFFE);
    @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    a = 32'hDEAD_BEEF; b = 32'h0101_0101; cin = 1'b0; sub = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_done_valid", done_valid, 0);
    check("arst_start_ready", start_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_sum", sum, 0);
    check("arst_cout", cout, 0);
    check("arst_ovf", ovf, 0);
    @(posedge clk);
    #1 check("arst_held_done_valid", done_valid, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
